axi_wr_burst_slave: RTL

AXI_WR_BURST_SLAVE -- requirements
Module: axi_wr_burst_slave

---
 rtl/axi_wr_burst_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi_wr_burst_slave.sv
// AXI write-burst slave: queues write addresses, streams data beats onto a
// simple backing-store write port and returns one write response per burst.
module axi_wr_burst_slave #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [AW-1:0]              axi_awaddr,
  input  logic [7:0]                 axi_awlen,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [DW-1:0]              axi_wdata,
  input  logic [DW/8-1:0]            axi_wstrb,
  input  logic                       axi_wlast,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic [1:0]                 axi_bresp,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [DW-1:0]              wr_data,
  output logic [DW/8-1:0]            wr_strb,
  output logic [$clog2(DEPTH):0]     aw_count,
  output logic                       err_wlast
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = DW / 8;
  localparam int BSH = $clog2(SW);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   addr_mem_r [DEPTH];
  logic [7:0]      len_mem_r  [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   cur_addr_r;
  logic [7:0]      cur_len_r, beat_r;
  logic            wready_r, bvalid_r, wr_en_r, err_wlast_r;
  logic [1:0]      bresp_r;
  logic [AW-1:0]   wr_addr_r;
  logic [DW-1:0]   wr_data_r;
  logic [SW-1:0]   wr_strb_r;
  logic            push_s, w_hs_s, last_s, resp_ok_s;
  logic [AW-1:0]   off_s;

  assign axi_awready = (count_r != CNT_FULL);
  assign push_s      = axi_awvalid && axi_awready;
  assign w_hs_s      = axi_wvalid && wready_r;
  // Early wlast and a missing wlast at beat==len both terminate the burst.
  assign last_s      = w_hs_s && (axi_wlast || (beat_r == cur_len_r));
  assign resp_ok_s   = axi_wlast && (beat_r == cur_len_r);
  assign off_s       = AW'(beat_r) << BSH;

  assign axi_wready = wready_r;
  assign axi_bvalid = bvalid_r;
  assign axi_bresp  = bresp_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign wr_strb    = wr_strb_r;
  assign aw_count   = count_r;
  assign err_wlast  = err_wlast_r;

  // Address queue storage; contents are don't-care until counted valid.
  always_ff @(posedge axi_aclk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= axi_awaddr;
      len_mem_r[wr_ptr_r]  <= axi_awlen;
    end
  end

  // Queue pointers and occupancy; the head is popped only when its burst ends.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (last_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, last_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // W channel next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CW{1'b0}}) state_s = DATA;
        else                       state_s = IDLE;
      end
      DATA: begin
        if (last_s) state_s = RESP;
        else        state_s = DATA;
      end
      RESP: begin
        if (bvalid_r && axi_bready) state_s = IDLE;
        else                        state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, registered handshake outputs and the beat write port.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r     <= IDLE;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      wr_strb_r   <= '0;
      err_wlast_r <= 1'b0;
      cur_addr_r  <= '0;
      cur_len_r   <= 8'd0;
      beat_r      <= 8'd0;
    end else begin
      state_r  <= state_s;
      wready_r <= (state_s == DATA);
      bvalid_r <= (state_s == RESP);
      wr_en_r  <= w_hs_s;
      if ((state_r == IDLE) && (state_s == DATA)) begin
        cur_addr_r <= addr_mem_r[rd_ptr_r];
        cur_len_r  <= len_mem_r[rd_ptr_r];
        beat_r     <= 8'd0;
      end
      if (w_hs_s) begin
        wr_addr_r <= cur_addr_r + off_s;
        wr_data_r <= axi_wdata;
        wr_strb_r <= axi_wstrb;
        beat_r    <= beat_r + 8'd1;
      end
      if (last_s) begin
        bresp_r <= resp_ok_s ? 2'b00 : 2'b10;
        if (!resp_ok_s) err_wlast_r <= 1'b1;
      end
    end
  end

endmodule
